// File: rtl/yarvi_bypass_if.sv
// Issue, operand-forwarding and commit signals of the yarvi bypass network.
interface yarvi_bypass_if #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned NREAD = 2
);
  logic                  issue_valid;
  logic [4:0]            issue_rd;
  logic                  issue_wb;
  logic                  issue_late;
  logic [XLEN-1:0]       ex_val;
  logic                  flush;
  logic [XLEN-1:0]       me_val;
  logic [5*NREAD-1:0]    rs_idx;
  logic [XLEN*NREAD-1:0] rf_val;
  logic [XLEN*NREAD-1:0] fwd_val;
  logic                  stall;
  logic                  commit_valid;
  logic [4:0]            commit_rd;
  logic [XLEN-1:0]       commit_val;
  logic [31:0]           stall_count;

  modport master (
    output issue_valid, issue_rd, issue_wb, issue_late, ex_val, flush,
           me_val, rs_idx, rf_val,
    input  fwd_val, stall, commit_valid, commit_rd, commit_val, stall_count
  );

  modport slave (
    input  issue_valid, issue_rd, issue_wb, issue_late, ex_val, flush,
           me_val, rs_idx, rf_val,
    output fwd_val, stall, commit_valid, commit_rd, commit_val, stall_count
  );
endinterface

// File: rtl/yarvi_bypass.sv
// Result-forwarding network: tracks in-flight results after issue, forwards the
// youngest matching value to each read port, and stalls on results not yet loaded.
module yarvi_bypass #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 1,
  parameter int unsigned NREAD      = 2
) (
  input  logic          clock,
  input  logic          reset_n,
  yarvi_bypass_if.slave bus
);
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 32;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             wb;
    logic             ready;
    logic [XLEN-1:0]  val;
  } entry_t;

  logic [CNT_W-1:0]            stall_cnt_q;
  logic [NREAD-1:0]            port_stall;
  logic [NREAD-1:0][XLEN-1:0]  port_val;
  entry_t                      last;
  logic                        commit_hit;

  // Unconditional shift pipeline; unready entries pick up me_val leaving LOAD_STAGE.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    entry_t d;
    entry_t q;

    if (k == 0) begin : g_head
      always_comb begin
        d       = '0;
        d.valid = bus.issue_valid & ~bus.flush;
        d.rd    = bus.issue_rd;
        d.wb    = bus.issue_wb;
        d.ready = ~bus.issue_late;
        d.val   = bus.issue_late ? '0 : bus.ex_val;
      end
    end else if (k == LOAD_STAGE + 1) begin : g_load
      always_comb begin
        d = g_stage[k-1].q;
        if (!d.ready) begin
          d.ready = 1'b1;
          d.val   = bus.me_val;
        end
      end
    end else begin : g_pass
      assign d = g_stage[k-1].q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) q <= '0;
      else          q <= d;
    end
  end

  // Per-port priority chain from oldest to youngest; the youngest hit wins.
  for (genvar n = 0; n < NREAD; n++) begin : g_port
    logic [REG_W-1:0] rs;
    logic [XLEN-1:0]  cv [DEPTH+1];
    logic             cs [DEPTH+1];

    assign rs        = bus.rs_idx[REG_W*n +: REG_W];
    assign cv[DEPTH] = bus.rf_val[XLEN*n +: XLEN];
    assign cs[DEPTH] = 1'b0;

    for (genvar k = 0; k < DEPTH; k++) begin : g_chain
      localparam bit EARLY = (k < LOAD_STAGE);
      logic hit;
      assign hit = g_stage[k].q.valid & g_stage[k].q.wb &
                   (g_stage[k].q.rd != REG_W'(0)) & (g_stage[k].q.rd == rs);
      assign cv[k] = !hit               ? cv[k+1] :
                     g_stage[k].q.ready ? g_stage[k].q.val : bus.me_val;
      assign cs[k] = hit ? (~g_stage[k].q.ready & EARLY) : cs[k+1];
    end

    assign port_val[n]   = cv[0];
    assign port_stall[n] = cs[0];
  end

  assign bus.fwd_val = port_val;
  assign bus.stall   = |port_stall;

  // Oldest stage is still forwarded above; its write lands in the register file next cycle.
  assign last         = g_stage[DEPTH-1].q;
  assign commit_hit   = last.valid & last.wb & (last.rd != REG_W'(0));
  assign bus.commit_valid = commit_hit;
  assign bus.commit_rd    = commit_hit ? last.rd : REG_W'(0);
  assign bus.commit_val   = !commit_hit ? '0 : (last.ready ? last.val : bus.me_val);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                stall_cnt_q <= '0;
    else if (bus.stall && (stall_cnt_q != '1))   stall_cnt_q <= stall_cnt_q + CNT_W'(1);
  end

  assign bus.stall_count = stall_cnt_q;
endmodule

// File: tb/tb_yarvi_bypass.sv
// Scoreboard bench for yarvi_bypass (DEPTH=3, LOAD_STAGE=1, NREAD=2, XLEN=64).
module tb_yarvi_bypass;
  typedef struct {
    logic [4:0]  rd;
    logic [63:0] val;
  } exp_t;

  localparam logic [63:0] RF0 = 64'hAAAA_0000_0000_00A0;
  localparam logic [63:0] RF1 = 64'hBBBB_0000_0000_00B1;

  logic clock;
  logic reset_n;
  int   n_vec;
  int   n_bad;
  int   exp_scnt;
  exp_t sbq[$];
  logic [63:0] fwd0, fwd1;

  yarvi_bypass_if #(.XLEN(64), .NREAD(2)) bus ();

  yarvi_bypass #(.XLEN(64), .DEPTH(3), .LOAD_STAGE(1), .NREAD(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  assign fwd0 = bus.fwd_val[63:0];
  assign fwd1 = bus.fwd_val[127:64];

  always #5 clock = ~clock;

  // Commit monitor: every register write must match the oldest queued expectation.
  always @(negedge clock) begin
    exp_t e;
    #3;
    if (reset_n === 1'b1 && bus.commit_valid === 1'b1) begin
      n_vec++;
      if (sbq.size() == 0) begin
        n_bad++;
        $display("FAIL commit_unexpected: got rd=%0d val=%h, want no commit", bus.commit_rd, bus.commit_val);
      end else begin
        e = sbq.pop_front();
        if (bus.commit_rd !== e.rd || bus.commit_val !== e.val) begin
          n_bad++;
          $display("FAIL commit_order: got rd=%0d val=%h, want rd=%0d val=%h", bus.commit_rd, bus.commit_val, e.rd, e.val);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  // One cycle: inputs set on the falling edge, captured at the next rising edge.
  task automatic drive(input logic v, input logic [4:0] rd, input logic wb, input logic late,
                       input logic [63:0] ev, input logic fl, input logic [63:0] cval,
                       input logic [63:0] me, input logic [4:0] r0, input logic [4:0] r1);
    exp_t e;
    @(negedge clock);
    bus.issue_valid = v;
    bus.issue_rd    = rd;
    bus.issue_wb    = wb;
    bus.issue_late  = late;
    bus.ex_val      = ev;
    bus.flush       = fl;
    bus.me_val      = me;
    bus.rs_idx      = {r1, r0};
    if (v && !fl && wb && rd != 5'd0) begin
      e.rd  = rd;
      e.val = late ? cval : ev;
      sbq.push_back(e);
    end
    #1;
  endtask

  task automatic idle(input logic [4:0] r0, input logic [4:0] r1, input logic [63:0] me);
    drive(1'b0, 5'd0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, me, r0, r1);
  endtask

  task automatic test_reset;
    bus.rs_idx = {5'd4, 5'd1};
    #1;
    n_vec++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
    n_vec++; if (bus.commit_valid !== 1'b0 || bus.commit_rd !== 5'd0 || bus.commit_val !== 64'd0) begin n_bad++; $display("FAIL reset_commit: got v=%b rd=%0d val=%h want 0/0/0", bus.commit_valid, bus.commit_rd, bus.commit_val); end
    n_vec++; if (fwd0 !== RF0 || fwd1 !== RF1) begin n_bad++; $display("FAIL reset_fwd: got %h %h want %h %h", fwd0, fwd1, RF0, RF1); end
    n_vec++; if (bus.stall_count !== 32'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", bus.stall_count); end
    @(negedge clock);
    reset_n = 1'b1;
    exp_scnt = 0;
    idle(5'd1, 5'd4, 64'd0);
    n_vec++; if (bus.commit_valid !== 1'b0 || fwd0 !== RF0 || fwd1 !== RF1 || bus.stall !== 1'b0) begin n_bad++; $display("FAIL post_reset: got cv=%b stall=%b fwd0=%h fwd1=%h want 0 0 rf rf", bus.commit_valid, bus.stall, fwd0, fwd1); end
  endtask

  task automatic test_alu;
    drive(1'b1, 5'd5, 1'b1, 1'b0, 64'h11, 1'b0, 64'd0, 64'd0, 5'd0, 5'd0);
    idle(5'd5, 5'd0, 64'd0);
    n_vec++; if (fwd0 !== 64'h11 || bus.stall !== 1'b0) begin n_bad++; $display("FAIL alu_stage0: got fwd0=%h stall=%b want 11 0", fwd0, bus.stall); end
    n_vec++; if (fwd1 !== RF1) begin n_bad++; $display("FAIL alu_port1_rf: got %h want %h", fwd1, RF1); end
    idle(5'd5, 5'd5, 64'd0);
    n_vec++; if (fwd0 !== 64'h11 || fwd1 !== 64'h11) begin n_bad++; $display("FAIL alu_stage1: got %h %h want 11 11", fwd0, fwd1); end
    idle(5'd5, 5'd0, 64'd0);
    n_vec++; if (bus.commit_valid !== 1'b1 || bus.commit_rd !== 5'd5 || bus.commit_val !== 64'h11) begin n_bad++; $display("FAIL alu_commit: got v=%b rd=%0d val=%h want 1/5/11", bus.commit_valid, bus.commit_rd, bus.commit_val); end
    n_vec++; if (fwd0 !== 64'h11) begin n_bad++; $display("FAIL alu_stage2_fwd: got %h want 11", fwd0); end
    idle(5'd5, 5'd0, 64'd0);
    n_vec++; if (fwd0 !== RF0 || bus.commit_valid !== 1'b0) begin n_bad++; $display("FAIL alu_retired: got fwd0=%h cv=%b want %h 0", fwd0, bus.commit_valid, RF0); end
  endtask

  task automatic test_late;
    drive(1'b1, 5'd6, 1'b1, 1'b1, 64'hDEAD, 1'b0, 64'hAB, 64'd0, 5'd0, 5'd0);
    idle(5'd6, 5'd0, 64'h77);
    n_vec++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL late_stall: got %b want 1", bus.stall); end
    exp_scnt++;
    idle(5'd6, 5'd0, 64'hAB);
    n_vec++; if (fwd0 !== 64'hAB || bus.stall !== 1'b0) begin n_bad++; $display("FAIL late_me_fwd: got fwd0=%h stall=%b want ab 0", fwd0, bus.stall); end
    idle(5'd6, 5'd0, 64'h55);
    n_vec++; if (bus.commit_valid !== 1'b1 || bus.commit_rd !== 5'd6 || bus.commit_val !== 64'hAB) begin n_bad++; $display("FAIL late_commit: got v=%b rd=%0d val=%h want 1/6/ab", bus.commit_valid, bus.commit_rd, bus.commit_val); end
    n_vec++; if (fwd0 !== 64'hAB) begin n_bad++; $display("FAIL late_stage2_fwd: got %h want ab", fwd0); end
    n_vec++; if (bus.stall_count !== 32'(exp_scnt)) begin n_bad++; $display("FAIL late_count: got %0d want %0d", bus.stall_count, exp_scnt); end
  endtask

  task automatic test_youngest;
    drive(1'b1, 5'd7, 1'b1, 1'b0, 64'h1, 1'b0, 64'd0, 64'd0, 5'd0, 5'd0);
    drive(1'b1, 5'd7, 1'b1, 1'b0, 64'h2, 1'b0, 64'd0, 64'd0, 5'd0, 5'd0);
    idle(5'd7, 5'd7, 64'd0);
    n_vec++; if (fwd0 !== 64'h2 || fwd1 !== 64'h2) begin n_bad++; $display("FAIL youngest_both: got %h %h want 2 2", fwd0, fwd1); end
    drive(1'b1, 5'd0, 1'b1, 1'b0, 64'h99, 1'b0, 64'd0, 64'd0, 5'd0, 5'd7);
    n_vec++; if (fwd0 !== RF0 || fwd1 !== 64'h2) begin n_bad++; $display("FAIL youngest_x0: got %h %h want %h 2", fwd0, fwd1, RF0); end
    idle(5'd0, 5'd0, 64'd0);
    n_vec++; if (fwd0 !== RF0 || fwd1 !== RF1) begin n_bad++; $display("FAIL rd0_nomatch: got %h %h want %h %h", fwd0, fwd1, RF0, RF1); end
    idle(5'd0, 5'd0, 64'd0);
    idle(5'd0, 5'd0, 64'd0);
    n_vec++; if (bus.commit_valid !== 1'b0) begin n_bad++; $display("FAIL rd0_commit: got %b want 0", bus.commit_valid); end
  endtask

  task automatic test_ports;
    drive(1'b1, 5'd10, 1'b1, 1'b0, 64'hA10, 1'b0, 64'd0, 64'd0, 5'd0, 5'd0);
    drive(1'b1, 5'd11, 1'b1, 1'b0, 64'hB11, 1'b0, 64'd0, 64'd0, 5'd0, 5'd0);
    drive(1'b1, 5'd13, 1'b0, 1'b0, 64'h13, 1'b0, 64'd0, 64'd0, 5'd10, 5'd11);
    n_vec++; if (fwd0 !== 64'hA10 || fwd1 !== 64'hB11) begin n_bad++; $display("FAIL ports_distinct: got %h %h want a10 b11", fwd0, fwd1); end
    idle(5'd13, 5'd10, 64'd0);
    n_vec++; if (fwd0 !== RF0 || fwd1 !== 64'hA10) begin n_bad++; $display("FAIL ports_nowb: got %h %h want %h a10", fwd0, fwd1, RF0); end
    for (int i = 0; i < 3; i++) idle(5'd0, 5'd0, 64'd0);
  endtask

  task automatic test_flush;
    drive(1'b1, 5'd12, 1'b1, 1'b0, 64'h12, 1'b0, 64'd0, 64'd0, 5'd0, 5'd0);
    drive(1'b1, 5'd9, 1'b1, 1'b0, 64'h9, 1'b1, 64'd0, 64'd0, 5'd0, 5'd0);
    idle(5'd9, 5'd12, 64'd0);
    n_vec++; if (fwd0 !== RF0 || fwd1 !== 64'h12 || bus.stall !== 1'b0) begin n_bad++; $display("FAIL flush_fwd: got %h %h stall=%b want %h 12 0", fwd0, fwd1, bus.stall, RF0); end
    idle(5'd9, 5'd0, 64'd0);
    n_vec++; if (bus.commit_valid !== 1'b1 || bus.commit_rd !== 5'd12 || bus.commit_val !== 64'h12) begin n_bad++; $display("FAIL flush_older_commit: got v=%b rd=%0d val=%h want 1/12/12", bus.commit_valid, bus.commit_rd, bus.commit_val); end
    idle(5'd9, 5'd0, 64'd0);
    n_vec++; if (bus.commit_valid !== 1'b0 || fwd0 !== RF0) begin n_bad++; $display("FAIL flush_bubble: got cv=%b fwd0=%h want 0 %h", bus.commit_valid, fwd0, RF0); end
  endtask

  task automatic test_stall_count;
    n_vec++; if (sbq.size() != 0) begin n_bad++; $display("FAIL drain: got %0d pending want 0", sbq.size()); end
    @(negedge clock);
    reset_n = 1'b0;
    sbq.delete();
    exp_scnt = 0;
    @(negedge clock);
    reset_n = 1'b1;
    drive(1'b1, 5'd3, 1'b1, 1'b1, 64'd0, 1'b0, 64'h33, 64'h33, 5'd0, 5'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'd3, 1'b1, 1'b1, 64'd0, 1'b0, 64'h33, 64'h33, 5'd3, 5'd0);
      n_vec++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL hold_stall: got %b want 1 (iter %0d)", bus.stall, i); end
      exp_scnt++;
    end
    idle(5'd0, 5'd0, 64'h33);
    n_vec++; if (bus.stall_count !== 32'(exp_scnt) || bus.stall !== 1'b0) begin n_bad++; $display("FAIL stall_count: got %0d stall=%b want %0d 0", bus.stall_count, bus.stall, exp_scnt); end
    // Reset mid-flight: pending entries are discarded.
    @(negedge clock);
    bus.rs_idx = {5'd3, 5'd3};
    reset_n = 1'b0;
    sbq.delete();
    exp_scnt = 0;
    #1;
    n_vec++; if (bus.commit_valid !== 1'b0 || bus.commit_rd !== 5'd0 || bus.commit_val !== 64'd0) begin n_bad++; $display("FAIL midreset_commit: got v=%b rd=%0d val=%h want 0/0/0", bus.commit_valid, bus.commit_rd, bus.commit_val); end
    n_vec++; if (bus.stall !== 1'b0 || bus.stall_count !== 32'd0 || fwd0 !== RF0) begin n_bad++; $display("FAIL midreset_state: got stall=%b cnt=%0d fwd0=%h want 0 0 %h", bus.stall, bus.stall_count, fwd0, RF0); end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) idle(5'd3, 5'd3, 64'h44);
    n_vec++; if (bus.stall !== 1'b0 || fwd0 !== RF0) begin n_bad++; $display("FAIL after_reset: got stall=%b fwd0=%h want 0 %h", bus.stall, fwd0, RF0); end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    exp_scnt = 0;
    clock = 1'b0;
    reset_n = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_rd = 5'd0;
    bus.issue_wb = 1'b0;
    bus.issue_late = 1'b0;
    bus.ex_val = 64'd0;
    bus.flush = 1'b0;
    bus.me_val = 64'd0;
    bus.rs_idx = 10'd0;
    bus.rf_val = {RF1, RF0};
    @(negedge clock);
    test_reset();
    test_alu();
    test_late();
    test_youngest();
    test_ports();
    test_flush();
    test_stall_count();
    n_vec++; if (sbq.size() != 0) begin n_bad++; $display("FAIL final_queue: got %0d pending want 0", sbq.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
